sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO, successor to the fixed 4x4 shared-RW FIFO.
//  - Independent write and read enables; a push and a pop can happen in the same cycle.
//  - Adds an occupancy count and programmable almost-full/almost-empty flags.
//  - Used as the generic stream buffer between datapath stages in one clock domain.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_mem.sv | 40 ++++
 rtl/sync_fifo_param.sv | 109 ++++++++++
 tb/tb_sync_fifo_param.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing helpers and parameter legality check for the FIFO family
// Purpose: constant functions used at elaboration time by sync_fifo_param and fifo_mem.
//   clog2        : ceiling log2 of a positive integer
//   ptr_width    : bits needed to address DEPTH entries (at least 1)
//   count_width  : bits needed to hold an occupancy of 0..DEPTH
//   params_legal : WIDTH/DEPTH/AF_LEVEL/AE_LEVEL range check
package fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int ptr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int count_width(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic bit params_legal(input int width, input int depth,
                                      input int af_level, input int ae_level);
    return (width >= 1) && (depth >= 2) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port RAM, DEPTH x WIDTH, registered read
// Purpose: storage array for sync_fifo_param.
// Ports:
//   clk    in  rising-edge clock
//   clear  in  synchronous active-high reset of the read register only (array is not cleared)
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   re     in  read enable; rdata holds when low
//   raddr  in  read address
//   rdata  out registered read data
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write: when raddr == waddr in the same edge the old word is returned,
  // which is what lets a full FIFO pop its oldest entry while overwriting that slot.
  always_ff @(posedge clk) begin
    if (clear)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with count and programmable flags
// Purpose: generic same-clock stream buffer; independent push/pop, occupancy count,
//   almost-full/almost-empty flags. Optional sticky error flags under macro FIFO_ERR_EN
//   (undefined: overflow/underflow tied to 0).
// Ports:
//   clk           in  rising-edge clock
//   clear         in  synchronous active-high reset
//   wr_en/din     in  push request and data
//   rd_en         in  pop request
//   dout          out registered pop data, one cycle after an accepted pop
//   empty/full    out count == 0 / count == DEPTH
//   almost_empty  out count <= AE_LEVEL
//   almost_full   out count >= AF_LEVEL
//   count         out occupancy, clog2(DEPTH+1) bits
//   overflow      out sticky push-while-full (FIFO_ERR_EN)
//   underflow     out sticky pop-while-empty (FIFO_ERR_EN)
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 8,
  parameter  int AF_LEVEL = 6,
  parameter  int AE_LEVEL = 1,
  localparam int CW       = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = ptr_width(DEPTH);

  if (!params_legal(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo_param: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_empty = (count <= CW'(AE_LEVEL));
  assign almost_full  = (count >= CW'(AF_LEVEL));

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push alongside it.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_next(wr_ptr);
      if (do_rd) rd_ptr <= ptr_next(rd_ptr);
      if (do_wr & ~do_rd)      count <= count + CW'(1);
      else if (do_rd & ~do_wr) count <= count - CW'(1);
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .clear (clear),
    .we    (do_wr & ~clear),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (do_rd & ~clear),
    .raddr (rd_ptr),
    .rdata (dout)
  );

`ifdef FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & full & ~rd_en) overflow  <= 1'b1;
      if (rd_en & empty)         underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param against a queue model
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;
  localparam int CW    = 4;
`ifdef FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clear = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             empty, full, almost_empty, almost_full, overflow, underflow;
  logic [CW-1:0]    count;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .clear(clear), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: contents as a queue, last popped word, sticky error bits.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout = '0;
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;

  wire [CW+3:0] act_status = {empty, full, almost_empty, almost_full, count};

  function automatic logic [CW+3:0] exp_status();
    int n;
    n = q.size();
    return {n == 0, n == DEPTH, n <= AE, n >= AF, CW'(n)};
  endfunction

  task automatic step(input bit w, input bit r, input logic [WIDTH-1:0] d);
    bit pop_ok, push_ok;
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    pop_ok  = r && (q.size() > 0);
    push_ok = w && ((q.size() < DEPTH) || pop_ok);
    if (ERR_EN && w && (q.size() == DEPTH) && !r) m_ovf = 1'b1;
    if (ERR_EN && r && (q.size() == 0)) m_unf = 1'b1;
    if (pop_ok) m_dout = q.pop_front();
    if (push_ok) q.push_back(d);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_clear(input int n);
    wr_en = 1'b0;
    rd_en = 1'b0;
    clear = 1'b1;
    repeat (n) @(posedge clk);
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    do_clear(2);
    step(1, 0, 8'h5A);
    step(1, 0, 8'hA5);
    step(0, 1, 8'h00);
    do_clear(2);
    checks++; if (act_status !== exp_status()) begin failures++;
      $display("FAIL reset_status: got %b want %b", act_status, exp_status()); end
    checks++; if (dout !== 8'h00) begin failures++;
      $display("FAIL reset_dout: got %h want 00", dout); end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++;
      $display("FAIL reset_err: got %b want 00", {overflow, underflow}); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, WIDTH'(i));
      checks++; if (act_status !== exp_status()) begin failures++;
        $display("FAIL fill_status[%0d]: got %b want %b", i, act_status, exp_status()); end
      checks++; if (almost_full !== (i >= 6)) begin failures++;
        $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, i >= 6); end
    end
    checks++; if (full !== 1'b1) begin failures++;
      $display("FAIL fill_full: got %b want 1", full); end
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 8'h00);
      checks++; if (dout !== WIDTH'(i)) begin failures++;
        $display("FAIL drain_dout[%0d]: got %h want %h", i, dout, WIDTH'(i)); end
      checks++; if (act_status !== exp_status()) begin failures++;
        $display("FAIL drain_status[%0d]: got %b want %b", i, act_status, exp_status()); end
    end
    checks++; if (empty !== 1'b1) begin failures++;
      $display("FAIL drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_wrap();
    int n_push[4] = '{5, 0, 8, 0};
    int n_pop[4]  = '{0, 5, 0, 8};
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < n_push[ph]; k++) step(1, 0, WIDTH'($urandom));
      for (int k = 0; k < n_pop[ph]; k++) begin
        step(0, 1, 8'h00);
        checks++; if (dout !== m_dout) begin failures++;
          $display("FAIL wrap_dout[%0d.%0d]: got %h want %h", ph, k, dout, m_dout); end
      end
      checks++; if (act_status !== exp_status()) begin failures++;
        $display("FAIL wrap_status[%0d]: got %b want %b", ph, act_status, exp_status()); end
    end
  endtask

  task automatic test_simultaneous();
    logic [WIDTH-1:0] oldest, prev;
    for (int k = 0; k < DEPTH; k++) step(1, 0, WIDTH'($urandom_range(0, 127)));
    oldest = q[0];
    step(1, 1, 8'hAA);
    checks++; if (dout !== oldest) begin failures++;
      $display("FAIL simul_full_dout: got %h want %h", dout, oldest); end
    checks++; if (count !== CW'(DEPTH)) begin failures++;
      $display("FAIL simul_full_count: got %0d want %0d", count, DEPTH); end
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 1, 8'h00);
      checks++; if (dout !== m_dout) begin failures++;
        $display("FAIL simul_drain[%0d]: got %h want %h", k, dout, m_dout); end
    end
    checks++; if (dout !== 8'hAA) begin failures++;
      $display("FAIL simul_last_out: got %h want aa", dout); end
    prev = dout;
    step(1, 1, 8'h55);
    checks++; if (count !== CW'(1)) begin failures++;
      $display("FAIL simul_empty_count: got %0d want 1", count); end
    checks++; if (dout !== prev) begin failures++;
      $display("FAIL simul_empty_dout: got %h want %h", dout, prev); end
    step(0, 1, 8'h00);
    checks++; if (dout !== 8'h55) begin failures++;
      $display("FAIL simul_empty_pop: got %h want 55", dout); end
  endtask

  task automatic test_errors();
    for (int k = 0; k < DEPTH; k++) step(1, 0, WIDTH'(8'h10 + k));
    step(1, 0, 8'h77);
    step(0, 0, 8'h00);
    checks++; if (count !== CW'(DEPTH)) begin failures++;
      $display("FAIL ovf_count: got %0d want %0d", count, DEPTH); end
    checks++; if (overflow !== m_ovf) begin failures++;
      $display("FAIL ovf_sticky: got %b want %b", overflow, m_ovf); end
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 1, 8'h00);
      checks++; if (dout !== WIDTH'(8'h10 + k)) begin failures++;
        $display("FAIL ovf_drain[%0d]: got %h want %h", k, dout, WIDTH'(8'h10 + k)); end
    end
    step(0, 1, 8'h00);
    checks++; if ({overflow, underflow} !== {m_ovf, m_unf}) begin failures++;
      $display("FAIL unf_flags: got %b want %b", {overflow, underflow}, {m_ovf, m_unf}); end
    checks++; if (underflow !== ERR_EN) begin failures++;
      $display("FAIL unf_value: got %b want %b", underflow, ERR_EN); end
    checks++; if (act_status !== exp_status()) begin failures++;
      $display("FAIL unf_status: got %b want %b", act_status, exp_status()); end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 4; k++) step(1, 0, WIDTH'($urandom));
    step(0, 1, 8'h00);
    step(1, 0, WIDTH'($urandom));
    do_clear(1);
    checks++; if (act_status !== exp_status()) begin failures++;
      $display("FAIL midrst_status: got %b want %b", act_status, exp_status()); end
    checks++; if ({dout, overflow, underflow} !== 10'h000) begin failures++;
      $display("FAIL midrst_out: got %h want 000", {dout, overflow, underflow}); end
    step(1, 0, 8'h3C);
    step(0, 1, 8'h00);
    checks++; if (dout !== 8'h3C) begin failures++;
      $display("FAIL midrst_push_pop: got %h want 3c", dout); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 45), WIDTH'($urandom));
      checks++; if (dout !== m_dout) begin failures++;
        $display("FAIL rand_dout[%0d]: got %h want %h", c, dout, m_dout); end
      checks++; if ({act_status, overflow, underflow} !== {exp_status(), m_ovf, m_unf}) begin
        failures++;
        $display("FAIL rand_status[%0d]: got %b want %b", c,
                 {act_status, overflow, underflow}, {exp_status(), m_ovf, m_unf}); end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_errors();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
